bram_stream_reader: RTL and testbench
=====================================

// Module: bram_stream_reader
// PURPOSE
//  Read-side initiator for the 2-cycle registered-read BRAM (bram_mem) in the transpose datapath.
//  Takes a burst command (base, count), issues sequential wrapping read addresses, and tracks the
//  fixed BRAM read latency. Words are delivered on a valid/ready output stream. Credit-limited
//  issue into a small output FIFO absorbs in-flight reads under backpressure, so no word is lost.
// PARAMETERS
//  DATAW      8              data width; must match the attached bram_mem
//  DEPTH      4              BRAM word count; must match the attached bram_mem
//  ADDRW      $clog2(DEPTH)  address width
//  FIFO_DEPTH 4              output FIFO entries; >=1 is functional, >=4 sustains 1 word/cycle
// PORTS
//  clk        in   1           single clock; all logic on posedge
//  rst_n      in   1           asynchronous, active-low reset
//  start      in   1           burst request; sampled only in IDLE
//  base_addr  in   ADDRW       first word address, sampled with start
//  count      in   ADDRW+1     words to read (0..DEPTH; values >DEPTH clamp to DEPTH), sampled with start
//  busy       out  1           high from the cycle after an accepted start until done
//  done       out  1           1-cycle pulse, burst complete
//  mem_raddr  out  ADDRW       to bram_mem.raddr
//  mem_rdata  in   DATAW       from bram_mem.rdata
//  out_data   out  DATAW       stream data (FIFO head)
//  out_valid  out  1           stream valid
//  out_ready  in   1           stream ready; a transfer occurs when out_valid&&out_ready
// BEHAVIOUR
//  Reset values: busy=0, done=0, mem_raddr=0, out_valid=0, out_data=0. FIFO, latency tags and counters are cleared.
//  FSM states:
//    IDLE  -> ISSUE on start with count>0. On start with count==0: done pulses next cycle, no reads, stays IDLE.
//    ISSUE -> DRAIN once the last read is issued.
//    DRAIN -> IDLE on the cycle after the final output transfer. done=1 and busy=0 in that cycle.
//  start while busy is ignored; base_addr and count are not re-sampled.
//  Read issue:
//    - One read per cycle in ISSUE, only when (fifo_occupancy + inflight) < FIFO_DEPTH.
//    - A read issued with mem_raddr=A in cycle t has mem_rdata=mem[A] valid in cycle t+2. It is
//      captured via a 2-deep valid-tag shift register and written to the FIFO at the end of t+2.
//    - mem_raddr holds its last value while not issuing.
//  Addressing: word i reads (base_addr+i) mod DEPTH. Wrap is correct for non-power-of-2 DEPTH.
//  Latency: start sampled in cycle 0 -> first mem_raddr in cycle 1 -> first out_valid in cycle 4.
//  Output stream:
//    - FIFO is first-word-fall-through and preserves order.
//    - out_data/out_valid stay stable while out_valid&&!out_ready.
//    - out_valid never asserts outside a burst.
//  Simultaneous FIFO push and pop in one cycle leaves occupancy unchanged, including when full.
//  rst_n low mid-burst: immediate return to IDLE. In-flight BRAM data is discarded, no done pulse.
//    The next burst after reset must emit no stale words.
//  Writes to the BRAM are outside this block. The user must not write addresses in an active burst.
// TESTING
//  T1 Memory preloaded with [0]=A0,[1]=A1,[2]=A2,[3]=A3; start base=0 count=4 in cycle 0, out_ready=1
//     -> mem_raddr 0,1,2,3 in cycles 1-4; out_data A0..A3 in cycles 4-7; done in cycle 8.
//  T2 Wrap: start base=3 count=3 -> stream A3,A0,A1; done once.
//  T3 Backpressure: count=4, out_ready=0 for 10 cycles
//     -> inflight+occupancy never exceeds FIFO_DEPTH; out_data stable at A0.
//     Release -> A0..A3 in order, no loss, no duplicates.
//  T4 count=0 -> done in cycle 1, busy stays 0, out_valid stays 0.
//  T5 Second start mid-burst (base=2) -> ignored; the original sequence completes unchanged.
//  T6 rst_n low after 2 words transferred -> out_valid, busy and done are 0 immediately.
//     New burst base=1 count=2 -> exactly A1,A2.

Source files
------------

// File: rtl/bram_stream_reader.sv
// Burst read initiator for a 2-cycle registered-read BRAM. Issues wrapping addresses under
// FIFO credit, tags reads through the fixed latency and delivers words on a valid/ready stream.
module bram_stream_reader #(
    parameter int DATAW      = 8,
    parameter int DEPTH      = 4,
    parameter int ADDRW      = $clog2(DEPTH),
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ADDRW-1:0] base_addr,
    input  logic [ADDRW:0]   count,
    output logic             busy,
    output logic             done,
    output logic [ADDRW-1:0] mem_raddr,
    input  logic [DATAW-1:0] mem_rdata,
    output logic [DATAW-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int CNTW = ADDRW + 1;
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int SW   = CW + 1;
    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [CNTW-1:0]   issue_left, out_left, count_clamped;
    logic [1:0]        tag;
    logic [DATAW-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     occ;
    logic [SW-1:0]     credit_sum;
    logic              accept, accept_burst, issue_fire, out_fire, last_out, push, pop;

    // Stream handshake: a word moves when out_valid && out_ready; while out_valid is high and
    // out_ready is low, out_data and out_valid are held.
    assign count_clamped = (count > DEPTH_C) ? DEPTH_C : count;
    assign accept        = (state == IDLE) && start;
    assign accept_burst  = accept && (count_clamped != '0);
    assign credit_sum    = SW'(occ) + SW'(tag[0]) + SW'(tag[1]);
    assign issue_fire    = (state == ISSUE) && (credit_sum < SW'(FIFO_DEPTH));
    assign out_valid     = (occ != '0);
    assign out_data      = fifo_mem[rd_ptr];
    assign out_fire      = out_valid && out_ready;
    assign last_out      = out_fire && (out_left == CNTW'(1));
    assign push          = tag[1];
    assign pop           = out_fire;
    assign busy          = (state != IDLE);

    function automatic logic [ADDRW-1:0] next_addr(input logic [ADDRW-1:0] a);
        return (a == ADDRW'(DEPTH - 1)) ? '0 : a + ADDRW'(1);
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_burst) state_nxt = ISSUE;
            ISSUE:   if (issue_fire && issue_left == CNTW'(1)) state_nxt = DRAIN;
            DRAIN:   if (last_out) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            done       <= 1'b0;
            mem_raddr  <= '0;
            issue_left <= '0;
            out_left   <= '0;
            tag        <= '0;
        end else begin
            state <= state_nxt;
            done  <= (accept && count_clamped == '0) || last_out;
            tag   <= {tag[0], issue_fire};
            // mem_raddr stops on the last issued address rather than running ahead.
            if (accept_burst)
                mem_raddr <= base_addr;
            else if (issue_fire && issue_left != CNTW'(1))
                mem_raddr <= next_addr(mem_raddr);
            if (accept_burst)
                issue_left <= count_clamped;
            else if (issue_fire)
                issue_left <= issue_left - CNTW'(1);
            if (accept_burst)
                out_left <= count_clamped;
            else if (out_fire)
                out_left <= out_left - CNTW'(1);
        end
    end

    // Credit guarantees a push never lands on a full FIFO unless a pop frees the same slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= mem_rdata;
                wr_ptr           <= next_ptr(wr_ptr);
            end
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: BRAM model, scoreboard monitor, table-driven bursts and
// hand-written sequences for latency, backpressure, ignored start and mid-burst reset.
module tb_bram_stream_reader;
    localparam int DATAW      = 8;
    localparam int DEPTH      = 4;
    localparam int ADDRW      = 2;
    localparam int FIFO_DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [ADDRW-1:0] base_addr = '0;
    logic [ADDRW:0]   count = '0;
    logic             busy, done, out_valid;
    logic             out_ready = 1'b0;
    logic [ADDRW-1:0] mem_raddr, raddr_q;
    logic [DATAW-1:0] mem_rdata, out_data;
    logic [DATAW-1:0] bram [DEPTH];

    logic [DATAW-1:0] exp_q[$];
    int               n_checks = 0;
    int               n_fail = 0;
    int               done_cnt = 0;
    int               xfer_cnt = 0;
    logic             prev_stall = 1'b0;
    logic [DATAW-1:0] prev_data = '0;

    typedef struct {
        logic [ADDRW-1:0] base;
        logic [ADDRW:0]   cnt;
        int               mode;
        int               exp_len;
    } vec_t;
    vec_t vecs [7];

    bram_stream_reader #(
        .DATAW(DATAW), .DEPTH(DEPTH), .ADDRW(ADDRW), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Two-cycle registered-read memory.
    always @(posedge clk) begin
        raddr_q   <= mem_raddr;
        mem_rdata <= bram[raddr_q];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (prev_stall) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_data_held", out_data, prev_data);
            end
            if (exp_q.size() == 0) check("valid_outside_burst", out_valid, 0);
            if (out_valid && out_ready) begin
                xfer_cnt++;
                check("word_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("stream_word", out_data, exp_q.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    function automatic logic pick_ready(input int mode);
        case (mode)
            0:       return 1'b1;
            1:       return 1'($urandom_range(0, 1));
            default: return ($urandom_range(0, 3) == 0);
        endcase
    endfunction

    // Call at posedge+1 of cycle 0: queues expected words and raises start for this cycle.
    task automatic drive_start(input logic [ADDRW-1:0] b, input logic [ADDRW:0] c);
        int n;
        n = (int'(c) > DEPTH) ? DEPTH : int'(c);
        for (int i = 0; i < n; i++) exp_q.push_back(bram[(int'(b) + i) % DEPTH]);
        base_addr = b;
        count     = c;
        start     = 1'b1;
    endtask

    task automatic wait_done(input string name, input int budget, input int mode);
        int k;
        k = 0;
        while (k < budget) begin
            step();
            start     = 1'b0;
            out_ready = pick_ready(mode);
            sample();
            k++;
            if (done) break;
        end
        check({name, "_done_seen"}, done, 1);
        step();
        out_ready = 1'b1;
        sample();
        check({name, "_done_single"}, done, 0);
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_queue_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int x0;
        for (int i = 0; i < DEPTH; i++) bram[i] = 8'hA0 + 8'(i);
        vecs[0] = '{base: 2'd3, cnt: 3'd3, mode: 0, exp_len: 3};
        vecs[1] = '{base: 2'd1, cnt: 3'd7, mode: 1, exp_len: 4};
        vecs[2] = '{base: 2'd2, cnt: 3'd1, mode: 0, exp_len: 1};
        vecs[3] = '{base: 2'd0, cnt: 3'd4, mode: 2, exp_len: 4};
        vecs[4] = '{base: 2'd3, cnt: 3'd4, mode: 1, exp_len: 4};
        vecs[5] = '{base: 2'd2, cnt: 3'd0, mode: 0, exp_len: 0};
        vecs[6] = '{base: 2'd1, cnt: 3'd5, mode: 2, exp_len: 4};

        // Reset state
        step();
        sample();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_raddr", mem_raddr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        step();
        rst_n = 1'b1;

        // T1 base latency and ordering
        step();
        out_ready = 1'b1;
        drive_start(2'd0, 3'd4);
        sample();
        for (int c = 1; c <= 9; c++) begin
            step();
            start = 1'b0;
            sample();
            if (c <= 4) check("t1_raddr", mem_raddr, 32'(c - 1));
            check("t1_valid", out_valid, (c >= 4 && c <= 7));
            check("t1_done", done, (c == 8));
            check("t1_busy", busy, (c <= 7));
        end
        check("t1_queue_drained", exp_q.size(), 0);
        exp_q.delete();

        // Table-driven bursts
        for (int v = 0; v < 7; v++) begin
            step();
            out_ready = 1'b1;
            x0 = xfer_cnt;
            drive_start(vecs[v].base, vecs[v].cnt);
            sample();
            wait_done("tbl", 100, vecs[v].mode);
            check("tbl_len", xfer_cnt - x0, vecs[v].exp_len);
        end

        // T3 backpressure for 10 cycles
        step();
        out_ready = 1'b0;
        drive_start(2'd0, 3'd4);
        sample();
        for (int c = 1; c <= 10; c++) begin
            step();
            start = 1'b0;
            sample();
        end
        check("t3_valid", out_valid, 1);
        check("t3_data", out_data, 8'hA0);
        check("t3_busy", busy, 1);
        check("t3_all_issued", mem_raddr, 3);
        x0 = xfer_cnt;
        wait_done("t3", 50, 0);
        check("t3_len", xfer_cnt - x0, 4);

        // T4 zero-length burst
        step();
        drive_start(2'd1, 3'd0);
        sample();
        step();
        start = 1'b0;
        sample();
        check("t4_done", done, 1);
        check("t4_busy", busy, 0);
        check("t4_valid", out_valid, 0);
        step();
        sample();
        check("t4_done_single", done, 0);

        // T5 start while busy is ignored
        step();
        x0 = xfer_cnt;
        drive_start(2'd0, 3'd4);
        sample();
        step();
        start = 1'b0;
        sample();
        step();
        base_addr = 2'd2;
        count     = 3'd3;
        start     = 1'b1;
        sample();
        wait_done("t5", 50, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            sample();
            check("t5_no_second_burst", busy, 0);
        end
        check("t5_len", xfer_cnt - x0, 4);

        // T6 reset after two transfers, then a clean burst
        step();
        x0 = xfer_cnt;
        drive_start(2'd0, 3'd4);
        sample();
        for (int c = 1; c <= 5; c++) begin
            step();
            start = 1'b0;
            sample();
        end
        check("t6_words_before_reset", xfer_cnt - x0, 2);
        step();
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
        x0 = xfer_cnt;
        drive_start(2'd1, 3'd2);
        sample();
        wait_done("t6", 50, 0);
        check("t6_len", xfer_cnt - x0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
